// File: rtl/mul_div_unit_if.sv
// Pipeline-side bundle for the multiply/divide unit: E-stage request fields in,
// busy flag, HI/LO architectural state and the read result out.
interface mul_div_unit_if;
  logic        Req;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDUAns;

  modport master (
    output Req, start, op, A, B,
    input  busy, HI, LO, E_MDUAns
  );

  modport slave (
    input  Req, start, op, A, B,
    output busy, HI, LO, E_MDUAns
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MDU owning HI/LO: fixed 5-cycle multiply, 10-cycle divide,
// single-cycle MTHI/MTLO, and a combinational MFHI/MFLO read port.
//
// state  | meaning
// S_IDLE | ready to accept; MTHI/MTLO complete here
// S_BUSY | mult/div in flight, counting down to commit
module mul_div_unit (
  input  logic              clk,
  input  logic              reset,
  mul_div_unit_if.slave     mdu
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_wr_en;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_accept = mdu.start & ~mdu.Req & ~r_busy;

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Result is formed from the operands latched at accept; the countdown only models latency.
  always_comb begin
    w_wr_en  = 1'b1;
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV: begin
        if (r_b == 32'd0) begin
          w_wr_en = 1'b0;
        end else if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
          w_res_lo = 32'h8000_0000;
          w_res_hi = 32'd0;
        end else begin
          w_res_lo = $signed(r_a) / $signed(r_b);
          w_res_hi = $signed(r_a) % $signed(r_b);
        end
      end
      OP_DIVU: begin
        if (r_b == 32'd0) begin
          w_wr_en = 1'b0;
        end else begin
          w_res_lo = r_a / r_b;
          w_res_hi = r_a % r_b;
        end
      end
      default: w_wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= 4'd0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (mdu.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_op    <= mdu.op;
                r_a     <= mdu.A;
                r_b     <= mdu.B;
                r_cnt   <= (mdu.op == OP_MULT || mdu.op == OP_MULTU) ? 4'd5 : 4'd10;
                r_busy  <= 1'b1;
                r_state <= S_BUSY;
              end
              OP_MTHI: r_hi <= mdu.A;
              OP_MTLO: r_lo <= mdu.A;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            if (w_wr_en) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mdu.busy     = r_busy;
  assign mdu.HI       = r_hi;
  assign mdu.LO       = r_lo;
  assign mdu.E_MDUAns = (mdu.op == OP_MFHI) ? r_hi :
                        (mdu.op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, busy-window
// length, accept gating by Req/busy, and reset abort.
module tb_mul_div_unit;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  mul_div_unit_if mdu_if ();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic rq, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    mdu_if.start = s;
    mdu_if.Req   = rq;
    mdu_if.op    = o;
    mdu_if.A     = a;
    mdu_if.B     = b;
  endtask

  // Accept an op, scramble operands during busy, check busy window and
  // that HI/LO hold old values, then check the committed result.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(1'b1, 1'b0, o, a, b);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'hDEAD_BEEF, 32'h0000_0000);
    for (int i = 0; i < ncyc; i++) begin
      chk({tag, " busy"}, {31'd0, mdu_if.busy}, 32'd1);
      chk({tag, " hi_hold"}, mdu_if.HI, old_hi);
      chk({tag, " lo_hold"}, mdu_if.LO, old_lo);
      @(negedge clk);
    end
    chk({tag, " busy_fall"}, {31'd0, mdu_if.busy}, 32'd0);
    chk({tag, " hi"}, mdu_if.HI, exp_hi);
    chk({tag, " lo"}, mdu_if.LO, exp_lo);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("rst hi", mdu_if.HI, 32'd0);
    chk("rst lo", mdu_if.LO, 32'd0);
    mdu_if.op = 4'd7;
    #1 chk("rst mfhi", mdu_if.E_MDUAns, 32'd0);
    mdu_if.op = 4'd0;

    run_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 5,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_mix", 4'd1, 32'h0001_0000, 32'hFFFF_0000, 5,
           32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 4'd4, 32'd7, 32'd0, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
    run_op("div_pos_neg", 4'd3, 32'd7, 32'hFFFF_FFFE, 10,
           32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu", 4'd4, 32'd100, 32'd7, 10,
           32'h0000_0001, 32'hFFFF_FFFD, 32'h0000_0002, 32'h0000_000E);
    run_op("div_zero", 4'd3, 32'hFFFF_FFF9, 32'd0, 10,
           32'h0000_0002, 32'h0000_000E, 32'h0000_0002, 32'h0000_000E);

    // MTHI blocked by Req, then taken
    drive(1'b1, 1'b1, 4'd5, 32'h1234_5678, 32'd0);
    @(negedge clk);
    chk("mthi_req hi", mdu_if.HI, 32'h0000_0002);
    chk("mthi_req busy", {31'd0, mdu_if.busy}, 32'd0);
    drive(1'b1, 1'b0, 4'd5, 32'h1234_5678, 32'd0);
    @(negedge clk);
    chk("mthi hi", mdu_if.HI, 32'h1234_5678);
    chk("mthi busy", {31'd0, mdu_if.busy}, 32'd0);
    drive(1'b0, 1'b0, 4'd7, 32'd0, 32'd0);
    #1 chk("mfhi ans", mdu_if.E_MDUAns, 32'h1234_5678);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd6, 32'hCAFE_BABE, 32'd0);
    @(negedge clk);
    chk("mtlo lo", mdu_if.LO, 32'hCAFE_BABE);
    drive(1'b0, 1'b0, 4'd8, 32'd0, 32'd0);
    #1 chk("mflo ans", mdu_if.E_MDUAns, 32'hCAFE_BABE);
    mdu_if.op = 4'd0;
    #1 chk("none ans", mdu_if.E_MDUAns, 32'd0);
    mdu_if.op = 4'd12;
    #1 chk("op12 ans", mdu_if.E_MDUAns, 32'd0);

    // Req on a MULT start suppresses it; op 9 is a no-op
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd1, 32'd3, 32'd3);
    @(negedge clk);
    chk("mult_req busy", {31'd0, mdu_if.busy}, 32'd0);
    drive(1'b1, 1'b0, 4'd9, 32'd3, 32'd3);
    @(negedge clk);
    chk("op9 busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("op9 hi", mdu_if.HI, 32'h1234_5678);
    chk("op9 lo", mdu_if.LO, 32'hCAFE_BABE);

    // MULT, then DIVU presented at busy cycle 2 is ignored; Req mid-op does not abort
    drive(1'b1, 1'b0, 4'd1, 32'd7, 32'd6);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("ign c1 busy", {31'd0, mdu_if.busy}, 32'd1);
    drive(1'b1, 1'b1, 4'd4, 32'd1000, 32'd3);
    mdu_if.Req = 1'b0;
    mdu_if.op  = 4'd7;
    #1 chk("mfhi while busy", mdu_if.E_MDUAns, 32'h1234_5678);
    mdu_if.op  = 4'd4;
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd0, 32'd0, 32'd0);
    chk("ign c2 busy", {31'd0, mdu_if.busy}, 32'd1);
    repeat (2) @(negedge clk);
    chk("ign c4 busy", {31'd0, mdu_if.busy}, 32'd1);
    chk("ign c4 hi", mdu_if.HI, 32'h1234_5678);
    @(negedge clk);
    chk("ign c5 busy", {31'd0, mdu_if.busy}, 32'd1);
    @(negedge clk);
    mdu_if.Req = 1'b0;
    chk("ign fall busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("ign hi", mdu_if.HI, 32'd0);
    chk("ign lo", mdu_if.LO, 32'd42);
    @(negedge clk);
    chk("ign no_div busy", {31'd0, mdu_if.busy}, 32'd0);

    // reset at busy cycle 4 of a DIV aborts it
    drive(1'b1, 1'b0, 4'd3, 32'd100, 32'd7);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort pre busy", {31'd0, mdu_if.busy}, 32'd1);
    reset = 1'b1;
    mdu_if.start = 1'b1;
    mdu_if.op    = 4'd5;
    mdu_if.A     = 32'h5555_5555;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("abort busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("abort hi", mdu_if.HI, 32'd0);
    chk("abort lo", mdu_if.LO, 32'd0);
    repeat (10) @(negedge clk);
    chk("abort late busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("abort late hi", mdu_if.HI, 32'd0);
    chk("abort late lo", mdu_if.LO, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high; clears all state.
REQ-003 Req  in  1  exception/interrupt taken this cycle; the E-stage instruction is being flushed.
REQ-004 start  in  1  E-stage instruction is an MDU instruction (qualifies op).
REQ-005 op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as NONE.
REQ-006 A  in  32  rs operand, forwarded value.
REQ-007 B  in  32  rt operand, forwarded value.
REQ-008 busy  out  1  multi-cycle operation in flight.
REQ-009 HI  out  32  architectural HI register.
REQ-010 LO  out  32  architectural LO register.
REQ-011 E_MDUAns  out  32  read result driven to the E/M pipeline register.

Function
REQ-012 Accept: on a rising edge with start=1, Req=0, busy=0; any other combination leaves all state unchanged.
REQ-013 Accepting op 1-4 latches A, B and op internally, loads cycle counter with 5 (MULT/MULTU) or 10 (DIV/DIVU), and sets busy=1.
REQ-014 busy rises on the accepting edge and stays high for exactly 5 (mult) or 10 (div) clock cycles.
REQ-015 Each edge while busy decrements the counter; on the edge where counter=1: HI/LO written, busy cleared, counter=0.
REQ-016 HI/LO keep old values throughout the operation; the new value is visible only after busy falls.
REQ-017 MULT: {HI,LO} = signed 64-bit A*B. MULTU: unsigned 64-bit product.
REQ-018 DIV: LO = signed quotient truncated toward zero; HI = remainder with dividend's sign.
REQ-019 DIVU: unsigned quotient into LO, remainder into HI.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no trap.
REQ-021 Divisor 0 (DIV or DIVU): full 10-cycle busy; HI and LO unchanged at completion.
REQ-022 MTHI/MTLO: on an accepting edge, HI<=A or LO<=A respectively; single-cycle, busy stays 0.
REQ-023 E_MDUAns combinational: HI when op=7, LO when op=8, else 0; independent of start, busy and Req.
REQ-024 Upstream stalls any MDU instruction while start&(op 1-4) or busy; the unit ignores start when busy=1 (REQ-012).
REQ-025 Req=1 suppresses only a new accept; an operation already in flight runs to completion and commits.
REQ-026 Operands are sampled only at accept; A/B changes during busy have no effect.
REQ-027 Arithmetic uses behavioural operators inside the unit; the fixed latency models the delay, with no iterative datapath.

Reset
REQ-028 reset=1 at an edge: HI=0, LO=0, busy=0, counter=0, latched operands/op=0.
REQ-029 Reset mid-operation aborts it; no HI/LO write occurs afterwards.
REQ-030 Reset has priority over start and Req on the same edge.

Verification
REQ-031 MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-033 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> HI/LO unchanged.
REQ-034 MTHI A=0x12345678 with Req=1 -> HI unchanged. Same stimulus with Req=0 -> HI=0x12345678 next cycle and E_MDUAns=0x12345678 for op=MFHI.
REQ-035 Start DIV; assert reset at busy cycle 4 -> busy=0, HI=LO=0, and no update at cycle 10.
REQ-036 Start MULT; then start=1, op=DIVU at busy cycle 2 -> ignored; MULT result only; busy falls after 5 cycles.
